cla_serial_adder: RTL and testbench
===================================

# cla_serial_adder

Nibble-serial multi-word adder built around the team's 4-bit carry look-ahead adder (`CLA`). It consumes one operand pair per transaction over a valid/ready handshake and feeds one 4-bit slice per cycle through a single `CLA` instance, registering the carry between slices. The result is presented on a valid/ready output port. It sits directly upstream of, and drives, the `CLA` slice. It trades latency for area in datapaths wider than 4 bits.

## Interface
- `NIBBLES`, default 4: number of 4-bit slices. Operand width `W = 4*NIBBLES`. Legal values are 1..16.
- `clk`, in, 1: the single clock. All state updates on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `in_valid`, in, 1: operand pair valid.
- `in_ready`, out, 1: block can accept operands.
- `a`, in, W: operand A.
- `b`, in, W: operand B.
- `cin`, in, 1: carry-in to slice 0.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: downstream accepts the result.
- `sum`, out, W: registered sum.
- `cout`, out, 1: registered carry-out of the top slice.

## Operation
- Exactly one `CLA` instance, connected positionally as (a, b, cin, sum, cout), all 4-bit except the carries.
  - Its inputs are the low nibbles of the operand shift registers and the carry register.
- FSM with states IDLE, ADD and DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid && in_ready`: load `a_sh`<=a, `b_sh`<=b, `c_reg`<=cin, `idx`<=0, clear the sum register, then go to ADD.
- **ADD** (`in_ready`=0, `out_valid`=0), each cycle:
  - `sum[4*idx +: 4]` <= CLA.sum.
  - `c_reg` <= CLA.cout.
  - `a_sh` and `b_sh` shift right by 4, zero-filled.
  - `idx` <= idx+1.
  - When `idx`==NIBBLES-1, latch `cout` <= CLA.cout and go to DONE.
- **DONE**
  - `out_valid`=1. `sum` and `cout` are held stable.
  - On `out_ready`, go to IDLE.
  - While `out_ready`=0, stay in DONE indefinitely with no change to outputs.
- Arithmetic is the exact W+1-bit result: {cout, sum} = a + b + cin. No saturation or overflow flag.
- `in_valid` is ignored outside IDLE. Upstream must hold `a`, `b` and `cin` only until the accepting edge.
- Operand inputs are sampled only on the accepting edge. Later changes have no effect on the running operation.
- Reset values:
  - State IDLE, so `in_ready`=1 during and after reset.
  - `out_valid`=0, `sum`=0, `cout`=0.
  - `c_reg`=0, `idx`=0, and both shift registers are 0.
- Reset mid-operation (ADD or DONE) aborts immediately. No `out_valid` pulse occurs for the aborted transaction.
- `in_ready` and `out_valid` are decoded from the state register only. There is no combinational path from `in_valid` or `out_ready` to them.

## Timing
- Accept edge is T0.
- ADD occupies edges T1..T_NIBBLES.
- `out_valid` rises after edge T_NIBBLES: latency is NIBBLES cycles from acceptance to result. Default: 4 cycles.
- Output transfer occurs on the first edge with `out_valid && out_ready`. `in_ready` returns high in the following cycle.
- Minimum issue interval is NIBBLES+2 cycles: one accept, NIBBLES add, one transfer.
- No overlap between transactions. A new accept is impossible in the same cycle as an output transfer.
- NIBBLES=1: ADD lasts one cycle and the FSM goes straight to DONE.
- Critical path is one `CLA` slice plus the carry register. There is no W-bit combinational carry chain.

## Test plan
- Default NIBBLES=4, a=0x0006, b=0x000B, cin=0, out_ready held 1:
  - Response: `out_valid` 4 cycles after accept, sum=0x0011, cout=0.
  - Repeat with cin=1: sum=0x0012, cout=0.
- Carry across all slices:
  - a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1.
  - a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1.
- Backpressure: out_ready=0 for 6 cycles after `out_valid` rises.
  - sum, cout and `out_valid` stay constant.
  - `in_ready` stays 0, and `in_valid` pulses with other operands during that window are ignored.
  - Transfer completes on the first cycle out_ready=1. `in_ready`=1 on the next cycle.
- Reset mid-ADD: assert rst asynchronously between edges T2 and T3.
  - Immediately: `out_valid`=0, sum=0, cout=0, `in_ready`=1.
  - No result is emitted after release. Next transaction 0x1234+0x4321, cin=0 -> sum=0x5555, cout=0.
- Back-to-back with out_ready=1 and in_valid=1 held: accepts occur exactly every 6 cycles, each result correct.
- Random regression:
  - 1000 random {a, b, cin} with random out_ready stalls, checked against {cout, sum} = a+b+cin.
  - Repeat the regression for NIBBLES=1 and NIBBLES=8.

Source files
------------

// File: rtl/cla_serial_adder.sv
// cla_serial_adder: nibble-serial W-bit adder that reuses one 4-bit carry look-ahead slice,
// registering the carry between slices; valid/ready on both sides.
module CLA (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] g, p;
  logic [4:0] c;
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) | (&p & cin);
    sum  = p ^ c[3:0];
    cout = c[4];
  end
endmodule

module cla_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  state_t        state, state_n;
  logic [W-1:0]  a_sh, b_sh;
  logic          c_reg;
  logic [IW-1:0] idx;
  logic [3:0]    s_nib;
  logic          c_nib;
  logic          last;
  CLA u_cla (a_sh[3:0], b_sh[3:0], c_reg, s_nib, c_nib);
  assign last      = idx == IW'(NIBBLES - 1);
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  always_comb begin
    state_n = (state == IDLE && in_valid) ? ADD  :
              (state == ADD && last)      ? DONE :
              (state == DONE && out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      c_reg <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && in_valid) begin
        a_sh  <= a;
        b_sh  <= b;
        c_reg <= cin;
        idx   <= '0;
        sum   <= '0;
      end else if (state == ADD) begin
        sum[4*idx +: 4] <= s_nib;
        c_reg <= c_nib;
        a_sh  <= a_sh >> 4;
        b_sh  <= b_sh >> 4;
        idx   <= idx + 1'b1;
        if (last) cout <= c_nib;
      end
    end
  end
endmodule

// File: tb/tb_cla_serial_adder.sv
// tb_cla_serial_adder: directed and random checks of the serial adder at NIBBLES=4, plus random runs at 1 and 8.
module tb_cla_serial_adder;
  logic clk = 0, rst = 1, rst_r = 1;
  always #5 clk = ~clk;
  int errors = 0, checks = 0;
  logic in_valid = 0, in_ready, out_valid, out_ready = 1, cin = 0, cout;
  logic [15:0] a = 0, b = 0, sum;
  bit done_g [2];

  cla_serial_adder #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [16:0] add16(input logic [15:0] x, input logic [15:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + 17'(c);
  endfunction

  // Transaction-level model: busy from accept until transfer, result visible NIBBLES cycles after accept.
  bit m_busy;
  int m_age, m_nacc;
  logic [16:0] m_res;
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_busy <= 0;
      m_age  <= 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy <= 1;
        m_age  <= 0;
        m_res  <= add16(a, b, cin);
        m_nacc <= m_nacc + 1;
      end
    end else if (m_age >= 4 && out_ready) m_busy <= 0;
    else if (m_age < 4) m_age <= m_age + 1;

  always @(negedge clk)
    if (rst) begin
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
    end else begin
      chk("in_ready", in_ready, !m_busy);
      chk("out_valid", out_valid, m_busy && m_age >= 4);
      if (m_busy && m_age >= 4) begin
        chk("sum", sum, m_res[15:0]);
        chk("cout", cout, m_res[16]);
      end
    end

  task automatic xact(input logic [15:0] xa, input logic [15:0] xb, input logic xc,
                      input logic [15:0] es, input logic ec);
    int lat = 0;
    @(posedge clk); #2;
    chk("pre_ready", in_ready, 1);
    a = xa; b = xb; cin = xc; in_valid = 1;
    @(posedge clk); #2;
    in_valid = 0; a = 16'hDEAD; b = 16'hBEEF; cin = ~xc;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #2;
      lat++;
    end
    chk("latency", lat, 4);
    chk("d_sum", sum, es);
    chk("d_cout", cout, ec);
  endtask

  for (genvar g = 0; g < 2; g++) begin : rg
    localparam int N  = g == 0 ? 1 : 8;
    localparam int W  = 4 * N;
    localparam int W1 = W + 1;
    logic iv = 0, ir, ov, ordy = 1, c = 0, co;
    logic [W-1:0] x = 0, y = 0, s;
    bit busy;
    int age, nacc;
    logic [W:0] res;
    cla_serial_adder #(.NIBBLES(N)) dut (
      .clk(clk), .rst(rst_r), .in_valid(iv), .in_ready(ir), .a(x), .b(y), .cin(c),
      .out_valid(ov), .out_ready(ordy), .sum(s), .cout(co)
    );
    always @(posedge clk or posedge rst_r)
      if (rst_r) begin
        busy <= 0;
        age  <= 0;
        nacc <= 0;
      end else if (!busy) begin
        if (iv) begin
          busy <= 1;
          age  <= 0;
          res  <= {1'b0, x} + {1'b0, y} + W1'(c);
          nacc <= nacc + 1;
        end
      end else if (age >= N && ordy) busy <= 0;
      else if (age < N) age <= age + 1;
    always @(negedge clk)
      if (!rst_r) begin
        chk($sformatf("n%0d_in_ready", N), ir, !busy);
        chk($sformatf("n%0d_out_valid", N), ov, busy && age >= N);
        if (busy && age >= N) begin
          chk($sformatf("n%0d_sum", N), s, res[W-1:0]);
          chk($sformatf("n%0d_cout", N), co, res[W]);
        end
      end
    initial begin
      int cyc;
      wait (!rst_r);
      cyc = 0;
      while (nacc < 1000 && cyc < 30000) begin
        @(posedge clk); #2;
        cyc++;
        iv = 1'($urandom_range(0, 1));
        x = W'($urandom);
        y = W'($urandom);
        c = 1'($urandom_range(0, 1));
        ordy = $urandom_range(0, 3) != 0;
      end
      chk($sformatf("n%0d_rand_count", N), nacc >= 1000, 1);
      iv = 0;
      done_g[g] = 1;
    end
  end

  initial begin
    int n0, cyc, acc[$];
    chk("pin_6_b", add16(16'h0006, 16'h000B, 0), 17'h00011);
    chk("pin_6_b_c", add16(16'h0006, 16'h000B, 1), 17'h00012);
    chk("pin_ffff_1", add16(16'hFFFF, 16'h0001, 0), 17'h10000);
    chk("pin_ffff_ffff", add16(16'hFFFF, 16'hFFFF, 1), 17'h1FFFF);
    chk("pin_1234", add16(16'h1234, 16'h4321, 0), 17'h05555);
    repeat (2) @(posedge clk);
    #2 rst = 0; rst_r = 0;
    xact(16'h0006, 16'h000B, 0, 16'h0011, 0);
    xact(16'h0006, 16'h000B, 1, 16'h0012, 0);
    xact(16'hFFFF, 16'h0001, 0, 16'h0000, 1);
    xact(16'hFFFF, 16'hFFFF, 1, 16'hFFFF, 1);
    // backpressure: result must hold and further operands must be ignored
    @(posedge clk); #2;
    a = 16'h00F0; b = 16'h0F0F; cin = 1; in_valid = 1; out_ready = 0;
    @(posedge clk); #2;
    in_valid = 0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #2;
      cyc++;
    end
    for (int i = 0; i < 6; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_ready", in_ready, 0);
      chk("bp_sum", sum, 16'h1000);
      chk("bp_cout", cout, 0);
      @(posedge clk); #2;
      in_valid = i[0]; a = 16'($urandom); b = 16'($urandom);
    end
    in_valid = 0; out_ready = 1;
    @(posedge clk); #2;
    chk("bp_release_ready", in_ready, 1);
    chk("bp_release_valid", out_valid, 0);
    // reset between T2 and T3 aborts the operation
    @(posedge clk); #2;
    a = 16'h7777; b = 16'h1111; cin = 0; in_valid = 1;
    @(posedge clk); #2;
    in_valid = 0;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1;
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_sum", sum, 0);
    chk("ar_cout", cout, 0);
    chk("ar_in_ready", in_ready, 1);
    @(posedge clk); #2;
    rst = 0;
    repeat (6) begin
      @(posedge clk); #2;
      chk("ar_no_result", out_valid, 0);
    end
    xact(16'h1234, 16'h4321, 0, 16'h5555, 0);
    // back-to-back with in_valid held high
    @(posedge clk); #2;
    a = 16'h0101; b = 16'h0202; cin = 0; in_valid = 1; out_ready = 1;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) acc.push_back(i);
      @(posedge clk); #2;
      a = a + 16'h1111;
    end
    in_valid = 0;
    chk("b2b_count", acc.size(), 4);
    for (int i = 1; i < acc.size(); i++) chk("b2b_gap", acc[i] - acc[i-1], 6);
    // random regression at NIBBLES=4
    n0 = m_nacc;
    cyc = 0;
    while (m_nacc - n0 < 1000 && cyc < 20000) begin
      @(posedge clk); #2;
      cyc++;
      in_valid = 1'($urandom_range(0, 1));
      a = 16'($urandom);
      b = 16'($urandom);
      cin = 1'($urandom_range(0, 1));
      out_ready = $urandom_range(0, 3) != 0;
    end
    chk("n4_rand_count", m_nacc - n0 >= 1000, 1);
    in_valid = 0;
    wait (done_g[0] && done_g[1]);
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
